dti_serialize: RTL



---
 rtl/dti_serialize_pkg.sv | 19 +
 rtl/dti_lane_mux.sv | 20 ++
 rtl/dti_serialize.sv | 103 ++++++++++
 3 files changed

// File: rtl/dti_serialize_pkg.sv
// Shared types and helpers for the DTI wide-to-narrow serializer.
// Holds the FSM state type, the lane-count width rule and the length clamp.
package dti_serialize_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   function automatic int lw_of(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   // Protects against a len field that can encode more lanes than exist.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned lanes);
      return (len > lanes - 1) ? lanes - 1 : len;
   endfunction

endpackage

// File: rtl/dti_lane_mux.sv
// Combinational lane selector: returns WIDTH bits of lane[sel] from a packed LANES*WIDTH vector.
// Out-of-range selects (non-power-of-two LANES) return zero.
module dti_lane_mux #(
   parameter int WIDTH = 16,
   parameter int LANES = 4,
   parameter int SW    = 2
) (
   input  logic [LANES*WIDTH-1:0] vec,
   input  logic [SW-1:0]          sel,
   output logic [WIDTH-1:0]       lane
);

   always_comb begin
      lane = '0;
      for (int i = 0; i < LANES; i++) begin
         if (sel == SW'(i)) lane = vec[i*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/dti_serialize.sv
// Serializes one wide DTI word (up to LANES lanes + len field) into single-lane beats.
// Define DTI_SERIALIZE_REVERSE_EN to emit lanes from index len down to 0.
//
// state | meaning
// IDLE  | no word held; din.ready asserted
// BUSY  | word held; emitting lane[cnt], reload allowed on the last beat
module dti_serialize
   import dti_serialize_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int LANES = 4,
   localparam int LW    = lw_of(LANES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      din_valid,
   output logic                      din_ready,
   input  logic [LANES*WIDTH+LW-1:0] din_data,
   output logic                      dout_valid,
   input  logic                      dout_ready,
   output logic [WIDTH:0]            dout_data
);

   state_t                 state, state_nxt;
   logic [LANES*WIDTH-1:0] word_reg, word_nxt;
   logic [LW-1:0]          len_reg, len_nxt;
   logic [LW-1:0]          cnt, cnt_nxt;
   logic [LW-1:0]          len_clamped;
   logic [LW-1:0]          cnt_start;
   logic [LW-1:0]          cnt_step;
   logic [WIDTH-1:0]       lane;
   logic                   last;
   logic                   load;

   assign len_clamped = LW'(clamp_len(32'(din_data[LANES*WIDTH +: LW]), 32'(LANES)));

`ifdef DTI_SERIALIZE_REVERSE_EN
   assign last      = (cnt == '0);
   assign cnt_start = len_clamped;
   assign cnt_step  = cnt - LW'(1);
`else
   assign last      = (cnt == len_reg);
   assign cnt_start = '0;
   assign cnt_step  = cnt + LW'(1);
`endif

   dti_lane_mux #(
      .WIDTH (WIDTH),
      .LANES (LANES),
      .SW    (LW)
   ) u_lane_mux (
      .vec  (word_reg),
      .sel  (cnt),
      .lane (lane)
   );

   assign dout_valid = (state == BUSY);
   assign dout_data  = {last, lane};
   // Ready on the last beat lets the next word load with no bubble.
   assign din_ready  = (state == IDLE) | (dout_ready & last);

   always_comb begin
      state_nxt = state;
      word_nxt  = word_reg;
      len_nxt   = len_reg;
      cnt_nxt   = cnt;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (din_valid) load = 1'b1;
         end
         BUSY: begin
            if (dout_ready) begin
               if (!last)          cnt_nxt   = cnt_step;
               else if (din_valid) load      = 1'b1;
               else                state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (load) begin
         state_nxt = BUSY;
         word_nxt  = din_data[LANES*WIDTH-1:0];
         len_nxt   = len_clamped;
         cnt_nxt   = cnt_start;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         word_reg <= '0;
         len_reg  <= '0;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         word_reg <= word_nxt;
         len_reg  <= len_nxt;
         cnt      <= cnt_nxt;
      end
   end

endmodule
